// File: rtl/keyboard_channel_debouncer.sv
// NCH-channel keyboard debouncer: per-channel press/release qualification on a shared
// sample strobe, latched input registers, rupt pulses, pending/overflow status, wired-OR read bus.
module keyboard_channel_debouncer #(
  parameter int NCH      = 2,
  parameter int KEYW     = 5,
  parameter int DEBOUNCE = 3
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                GOJAM,
  input  logic                SAMPLE,
  input  logic [NCH*KEYW-1:0] KEYIN,
  input  logic [NCH-1:0]      RCH_,
  output logic [KEYW-1:0]     CHOUT,
  output logic [NCH-1:0]      KYRPT,
  output logic [NCH-1:0]      KEYPEND,
  output logic [NCH-1:0]      KEYOVF
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_e;

  state_e          st_q    [NCH];
  state_e          st_d    [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [KEYW-1:0] smp_q   [NCH];
  logic [KEYW-1:0] smp_d   [NCH];
  logic [KEYW-1:0] chreg_q [NCH];
  logic [KEYW-1:0] chreg_d [NCH];
  logic [KEYW-1:0] key     [NCH];
  logic [NCH-1:0]  rpt_q, rpt_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic [NCH-1:0]  acc;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      key[i] = KEYIN[i*KEYW +: KEYW];
    end
  end

  // While in PRESS the candidate code always equals the previous sample, so the
  // sample register doubles as the code register.
  always_comb begin
    acc    = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      smp_d[i]   = smp_q[i];
      chreg_d[i] = chreg_q[i];
      if (SAMPLE) begin
        smp_d[i] = key[i];
        case (st_q[i])
          IDLE: begin
            if (key[i] != '0) begin
              if (DEBOUNCE == 1) begin
                acc[i] = 1'b1;
              end else begin
                st_d[i]  = PRESS;
                cnt_d[i] = CW'(1);
              end
            end
          end
          PRESS: begin
            if (key[i] == '0) begin
              st_d[i]  = IDLE;
              cnt_d[i] = '0;
            end else if (key[i] == smp_q[i]) begin
              if (cnt_q[i] == DB_LAST) acc[i] = 1'b1;
              else                     cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
              cnt_d[i] = CW'(1);
            end
          end
          HELD: begin
            if (key[i] != '0) begin
              cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
              st_d[i]  = IDLE;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end
        endcase
        if (acc[i]) begin
          chreg_d[i] = key[i];
          st_d[i]    = HELD;
          cnt_d[i]   = '0;
        end
      end

      if (acc[i] && !RCH_[i]) begin
        pend_d[i] = 1'b1;
      end else if (acc[i]) begin
        ovf_d[i]  = ovf_q[i] | pend_q[i];
        pend_d[i] = 1'b1;
      end else if (!RCH_[i]) begin
        pend_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end
    end
    rpt_d = acc;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]    <= IDLE;
        cnt_q[i]   <= '0;
        smp_q[i]   <= '0;
        chreg_q[i] <= '0;
      end
      rpt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else if (GOJAM) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]    <= IDLE;
        cnt_q[i]   <= '0;
        smp_q[i]   <= '0;
        chreg_q[i] <= '0;
      end
      rpt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]    <= st_d[i];
        cnt_q[i]   <= cnt_d[i];
        smp_q[i]   <= smp_d[i];
        chreg_q[i] <= chreg_d[i];
      end
      rpt_q  <= rpt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    CHOUT = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!RCH_[i]) CHOUT = CHOUT | chreg_q[i];
    end
  end

  assign KYRPT   = rpt_q;
  assign KEYPEND = pend_q;
  assign KEYOVF  = ovf_q;

endmodule

// File: doc/keyboard_channel_debouncer.md
Name: keyboard_channel_debouncer

Overview:
Parametrised successor to the fixed two-keyboard input logic of the Inout II block. It accepts NCH keyboard/discrete channels, each KEYW bits wide, and debounces each channel on a shared sample strobe. A qualified keypress latches into a per-channel input register and raises a one-cycle keyboard rupt. It also tracks pending/overflow status, which is cleared by a channel read. Read data leaves on a wired-OR channel bus, as the other channel-input logic in the design does.

Parameters:
NCH, 2, number of keyboard channels
KEYW, 5, key-code width per channel; code 0 means no key
DEBOUNCE, 3, consecutive identical samples required to accept a press or release (legal range 1..15)

Ports:
CLOCK  in  1  single system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
GOJAM  in  1  synchronous clear of all state, same effect as rst
SAMPLE  in  1  one-cycle sample strobe; debounce logic advances only when high
KEYIN  in  NCH*KEYW  raw key codes; channel i occupies bits [i*KEYW +: KEYW]
RCH_  in  NCH  active-low per-channel read select
CHOUT  out  KEYW  wired-OR of CHREG[i] over all selected channels; 0 when none selected
KYRPT  out  NCH  registered one-cycle rupt pulse per channel
KEYPEND  out  NCH  latched code not yet read
KEYOVF  out  NCH  new code latched while the previous one was still unread

Behaviour:
- Reset/clear:
  - rst (async) or GOJAM (sync, next edge) sets every channel to IDLE, count 0, sample register 0, CHREG 0.
  - KYRPT, KEYPEND and KEYOVF go to 0. CHOUT then reads 0.
- Sample register: SMP[i] <= KEYIN[i] on edges where SAMPLE=1. Debounce decisions use the new sample (KEYIN at that edge).
- Per-channel FSM; count is ceil(log2(DEBOUNCE+1)) bits, saturating. All transitions occur only on SAMPLE edges:
  - IDLE:
    - nonzero sample: code<=sample, count<=1, go to PRESS.
    - If DEBOUNCE=1, accept immediately instead: see accept action.
  - PRESS:
    - sample==code: count++. When count reaches DEBOUNCE, accept.
    - different nonzero sample: code<=sample, count<=1.
    - zero sample: go to IDLE, count<=0.
  - Accept action (same edge): CHREG<=code, KYRPT[i]<=1, go to HELD, count<=0.
  - HELD:
    - zero sample: count++. At DEBOUNCE, go to IDLE, count<=0.
    - nonzero sample (any code): count<=0. A new code is not latched until release is qualified; no auto-repeat.
- KYRPT: high exactly one cycle, the cycle after the accept edge. Otherwise 0.
- KEYPEND/KEYOVF, evaluated per edge:
  - accept and read in same cycle: KEYPEND stays 1; KEYOVF unchanged; CHOUT that cycle shows the old CHREG.
  - accept, no read: KEYOVF<=KEYOVF|KEYPEND; KEYPEND<=1.
  - read only (RCH_[i]=0): KEYPEND<=0, KEYOVF<=0.
- CHOUT is combinational from CHREG and RCH_, with zero latency. Multiple selects OR together.
- Channels are fully independent. Simultaneous accepts on several channels give simultaneous KYRPT bits; there is no priority logic here.
- SAMPLE held high continuously is legal: the block debounces every cycle.
- rst asserted mid-debounce aborts with no KYRPT. After release, the first accept needs a full DEBOUNCE samples.

Test Plan:
- NCH=2, DEBOUNCE=3: hold KEYIN ch0=5'o21 for 3 SAMPLE pulses -> KYRPT=2'b01 for one cycle after the 3rd; KEYPEND[0]=1; RCH_=2'b10 gives CHOUT=5'o21; the next edge clears KEYPEND[0].
- Bounce: ch1 samples 7,7,0,7,7,7 -> exactly one KYRPT[1], after the 6th sample; CHREG1=7. Samples 7,7,3,3,3 -> KYRPT[1] after the 5th; CHREG1=3.
- Hold without release: ch0=4 held for 10 samples -> exactly one KYRPT. Then 3 zero samples followed by 3 samples of 4 -> a second KYRPT.
- Overflow: ch0 accepts 1, is released, then accepts 2 with no read -> KEYOVF[0]=1, CHOUT=2 when read. The read clears KEYPEND[0] and KEYOVF[0].
- Accept and read on the same edge -> CHOUT shows the old value; KEYPEND stays 1; KEYOVF stays 0. Both channels read together (CHREG 5'o01 and 5'o20) -> CHOUT=5'o21.
- rst pulse after 2 of 3 press samples -> no KYRPT; all outputs 0. GOJAM mid-HELD -> IDLE; the held key then re-qualifies after 3 samples and gives a KYRPT.
